add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_if.sv | 28 ++
 rtl/add_arbiter.sv | 80 ++++++++
 tb/tb_add_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_arbiter_if.sv
// Requester/result bundle for the two-port adder arbiter.
// The master modport belongs to the requester side; the slave modport belongs to the arbiter.
interface add_arbiter_if #(parameter int WIDTH = 8);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] op0_a;
  logic [WIDTH-1:0] op0_b;
  logic [WIDTH-1:0] op1_a;
  logic [WIDTH-1:0] op1_b;
  logic             sat;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_id;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  modport master (
    output req_valid, op0_a, op0_b, op1_a, op1_b, sat, res_ready,
    input  req_ready, res_valid, res_data, res_carry, res_id, cnt0, cnt1
  );

  modport slave (
    input  req_valid, op0_a, op0_b, op1_a, op1_b, sat, res_ready,
    output req_ready, res_valid, res_data, res_carry, res_id, cnt0, cnt1
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding one registered adder; latency 1 cycle, one op per cycle.
// Backpressure: req_ready drops while a result is held and res_ready is low.
module add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  add_arbiter_if.slave bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic             ptr;
  logic             can_accept;
  logic [1:0]       grant;
  logic             xfer;
  logic             gid;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] data_q;
  logic             carry_q;
  logic             id_q;
  logic [7:0]       cnt0_q;
  logic [7:0]       cnt1_q;

  assign can_accept = (state == EMPTY) || bus.res_ready;

  // Gated by rst_n so req_ready is zero the instant reset asserts.
  always_comb begin
    grant = 2'b00;
    if (rst_n && can_accept) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign xfer  = |grant;
  assign gid   = grant[1];
  assign a_sel = gid ? bus.op1_a : bus.op0_a;
  assign b_sel = gid ? bus.op1_b : bus.op0_b;
  assign sum   = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ptr     <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
    end else if (xfer) begin
      state   <= FULL;
      data_q  <= (bus.sat && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      carry_q <= sum[WIDTH];
      id_q    <= gid;
      ptr     <= ~gid;
      if (gid) cnt1_q <= cnt1_q + 8'd1;
      else     cnt0_q <= cnt0_q + 8'd1;
    end else if (bus.res_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.req_ready = grant;
  assign bus.res_valid = (state == FULL);
  assign bus.res_data  = data_q;
  assign bus.res_carry = carry_q;
  assign bus.res_id    = id_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: vector table, directed corner sequences and random traffic vs a reference model.
module tb_add_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_arbiter_if #(.WIDTH(8)) bus ();

  add_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: result slot, last grantee, per-requester counts.
  bit         m_full;
  logic [7:0] m_data;
  bit         m_carry;
  bit         m_id;
  int         m_last;
  int         m_cnt [2];

  typedef struct {
    logic [1:0] valid;
    logic [7:0] a0, b0, a1, b1;
    logic       sat;
    logic [1:0] exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_id;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full  = 0;
    m_data  = 8'h00;
    m_carry = 0;
    m_id    = 0;
    m_last  = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  // Who should win this cycle: nobody if the slot is blocked, else the only
  // requester, else whoever did not win last time.
  function automatic int exp_grant(input logic [1:0] v, input logic rr);
    if (m_full && !rr) return -1;
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return (m_last == 0) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic apply(input logic [1:0] v, input logic [7:0] a0, b0, a1, b1,
                       input logic s, input logic rr, output logic [1:0] rdy_seen);
    int g;
    int sum;
    logic [1:0] exp_rdy;
    bus.req_valid = v;
    bus.op0_a = a0; bus.op0_b = b0;
    bus.op1_a = a1; bus.op1_b = b1;
    bus.sat = s;
    bus.res_ready = rr;
    #1;
    g = exp_grant(v, rr);
    exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    rdy_seen = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("res_valid", bus.res_valid, m_full);
    if (m_full) begin
      chk("res_data", bus.res_data, m_data);
      chk("res_carry", bus.res_carry, m_carry);
      chk("res_id", bus.res_id, m_id);
    end
    chk("cnt0", bus.cnt0, m_cnt[0]);
    chk("cnt1", bus.cnt1, m_cnt[1]);
    @(posedge clk);
    if (g >= 0) begin
      sum = (g == 0) ? (a0 + b0) : (a1 + b1);
      m_carry = (sum > 255);
      m_data  = (s && sum > 255) ? 8'hFF : 8'(sum % 256);
      m_id    = (g == 1);
      m_full  = 1;
      m_last  = g;
      m_cnt[g] = (m_cnt[g] + 1) % 256;
    end else if (rr) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] rdy;
  logic [1:0] alt_exp [4];

  initial begin
    bus.req_valid = 2'b11;
    bus.op0_a = 0; bus.op0_b = 0; bus.op1_a = 0; bus.op1_b = 0;
    bus.sat = 0; bus.res_ready = 0;
    model_reset();

    // Reset state, with both requesters asserting.
    #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 8'h00);
    chk("rst_res_carry", bus.res_carry, 1'b0);
    chk("rst_res_id", bus.res_id, 1'b0);
    chk("rst_cnt0", bus.cnt0, 8'h00);
    chk("rst_cnt1", bus.cnt1, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //          valid  a0     b0     a1     b1     sat  rdy    vld  data   cy  id
    tbl[0] = '{2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1, 8'h46, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 8'h00, 8'h00, 8'hFF, 8'h01, 1'b0, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 8'h10, 8'h20, 8'h55, 8'h55, 1'b0, 2'b01, 1'b1, 8'h30, 1'b0, 1'b0};
    tbl[3] = '{2'b11, 8'h01, 8'h01, 8'hF0, 8'h20, 1'b1, 2'b10, 1'b1, 8'hFF, 1'b1, 1'b1};
    tbl[4] = '{2'b11, 8'h80, 8'h80, 8'h01, 8'h01, 1'b1, 2'b01, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{2'b10, 8'h00, 8'h00, 8'h7F, 8'h01, 1'b1, 2'b10, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{2'b00, 8'h11, 8'h11, 8'h22, 8'h22, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{2'b10, 8'h09, 8'h09, 8'h03, 8'h04, 1'b0, 2'b10, 1'b1, 8'h07, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].valid, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].sat, 1'b1, rdy);
      chk("tbl_ready", rdy, tbl[i].exp_ready);
      #1;
      chk("tbl_valid", bus.res_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk("tbl_data", bus.res_data, tbl[i].exp_data);
        chk("tbl_carry", bus.res_carry, tbl[i].exp_carry);
        chk("tbl_id", bus.res_id, tbl[i].exp_id);
      end
    end
    chk("tbl_cnt0", bus.cnt0, 8'd3);
    chk("tbl_cnt1", bus.cnt1, 8'd4);

    // Alternating grants from a fresh pointer.
    do_reset();
    alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      apply(2'b11, 8'(i), 8'h01, 8'(i + 8'h10), 8'h01, 1'b0, 1'b1, rdy);
      chk("alt_grant", rdy, alt_exp[i]);
      #1;
      chk("alt_res_id", bus.res_id, alt_exp[i][1]);
    end
    chk("alt_cnt0", bus.cnt0, 8'd2);
    chk("alt_cnt1", bus.cnt1, 8'd2);

    // Held result under backpressure, then release with a same-cycle transfer.
    apply(2'b01, 8'h21, 8'h22, 8'h00, 8'h00, 1'b0, 1'b1, rdy);
    for (int i = 0; i < 3; i++) begin
      apply(2'b01, 8'(8'h40 + i), 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, rdy);
      chk("hold_ready", rdy, 2'b00);
      #1;
      chk("hold_data", bus.res_data, 8'h43);
    end
    apply(2'b01, 8'h50, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, rdy);
    chk("release_ready", rdy, 2'b01);
    #1;
    chk("release_data", bus.res_data, 8'h55);

    // Counter wrap after 256 transfers.
    do_reset();
    for (int i = 0; i < 256; i++)
      apply(2'b01, 8'($urandom), 8'($urandom), 8'h00, 8'h00, 1'($urandom), 1'b1, rdy);
    #1;
    chk("cnt0_wrap", bus.cnt0, 8'h00);
    chk("cnt0_wrap_valid", bus.res_valid, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      apply(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0), rdy);

    // Asynchronous reset while a result is held.
    apply(2'b10, 8'h00, 8'h00, 8'h33, 8'h44, 1'b0, 1'b1, rdy);
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    #1;
    chk("pre_arst_valid", bus.res_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.res_valid, 1'b0);
    chk("arst_cnt0", bus.cnt0, 8'h00);
    chk("arst_cnt1", bus.cnt1, 8'h00);
    chk("arst_ready", bus.req_ready, 2'b00);
    chk("arst_data", bus.res_data, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1, rdy);
    chk("post_arst_grant", rdy, 2'b01);
    apply(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b1, rdy);
    chk("post_arst_grant2", rdy, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
